button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Input-side counterpart to the LED driver: samples raw push-button/switch pins and turns them into clean logic.
- Per button, provides a debounced level, a one-cycle press pulse and a one-cycle release pulse.
- Sits between top-level board pins and user logic, for example the LED pattern sequencer.
- Uses a single clock domain; pins are asynchronous and are synchronized internally.

Parameters:
- NUM_BUTTONS, 4: number of independent button channels.
- STABLE_TIMER_BIT, 17: a change is accepted after 2^STABLE_TIMER_BIT+1 consecutive mismatching samples (about 10.9 ms at 12 MHz).
- ACTIVE_LOW, 1: 1 means a pressed pin reads 0 (pull-up board); 0 means a pressed pin reads 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  NUM_BUTTONS  raw asynchronous button pins.
- btn_state  output  NUM_BUTTONS  debounced level; 1 = pressed, regardless of ACTIVE_LOW.
- btn_press  output  NUM_BUTTONS  one-cycle pulse on an accepted released-to-pressed change.
- btn_release  output  NUM_BUTTONS  one-cycle pulse on an accepted pressed-to-released change.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - btn_state, btn_press and btn_release are all 0.
  - Both synchronizer stages are loaded with the released level (1 if ACTIVE_LOW, else 0), so a button held through reset produces no spurious press until the full 2-stage sync + 2^B+1 stable sequence completes after reset.
  - All counters are 0.
- Synchronizer: two flops per bit. The second stage is XORed with ACTIVE_LOW to give the normalized sample s (1 = pressed).
- Per-channel counter (width B+1, where B = STABLE_TIMER_BIT), evaluated each clk edge, non-reset:
  - s == btn_state: counter <= 0.
  - s != btn_state and counter[B] == 0: counter <= counter + 1.
  - s != btn_state and counter[B] == 1: counter <= 0, btn_state <= s. Also pulse btn_press if s == 1, or btn_release if s == 0.
- Pulses:
  - Registered and high for exactly one cycle; deasserted on the following edge.
  - btn_press and btn_release are never both high for the same bit.
- Latency: a clean pin transition reaches btn_state and its pulse after exactly 2^B+3 clk edges (2 sync edges + 2^B count edges + 1 commit edge).
- Glitch rejection: any return of s to btn_state before commit clears the counter. No output change results, and the next mismatch restarts counting from 0.
- Channels are fully independent. Simultaneous changes on several bits commit on the same edge when their timings match.
- Reset mid-count: the count is discarded and outputs return to 0 on the reset edge. After release of rst, a still-held button needs the full 2^B+3 latency again.
- No wrap-around: counter saturation is impossible because commit clears it at 2^B.
- Bounce during the commit edge has no effect. The new sample only affects the next cycle's comparison.

Decomposition:
- Shared header (blink_defs.vh): default STABLE_TIMER_BIT and the board ACTIVE_LOW value, shared with the LED timer constants.
- Sub-module debounce_channel: one bit, containing the synchronizer, counter, state and pulse registers.
  - Same clk/rst and parameters STABLE_TIMER_BIT and ACTIVE_LOW.
  - Instantiated NUM_BUTTONS times in a generate loop.
- The top level only concatenates outputs.

Test Plan:
- Bench parameters: STABLE_TIMER_BIT=3, ACTIVE_LOW=1, NUM_BUTTONS=4.
- Reset: btn_in=4'b1111 held with rst=1 for 3 cycles, then released. btn_state=0 and btn_press=0 for 20 cycles.
- Clean press: btn_in[0] 1->0 just before edge 0 and held. btn_state[0]=1 and btn_press[0]=1 after edge 11; btn_press[0]=0 after edge 12; btn_release never fires.
- Clean release: from pressed state, btn_in[0] 0->1 and held. btn_release[0] pulses for one cycle after edge 11 and btn_state[0]=0.
- Glitch: btn_in[1] low for 8 cycles, high for 1 cycle, then low and held. No change at the first attempt; btn_press[1] fires 11 edges after the final falling edge.
- Simultaneous: btn_in 4'b1111->4'b0101 on one edge. btn_state=4'b1010 and btn_press=4'b1010 on the same cycle after edge 11.
- Reset mid-count: btn_in[2] pressed and rst pulsed at edge 6. No press at edge 11; btn_press[2] fires 11 edges after rst deasserts.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared constants for the button debouncer: board defaults and the
// per-channel counter action type.
package button_debouncer_pkg;

    localparam int unsigned DEFAULT_NUM_BUTTONS      = 4;
    localparam int unsigned DEFAULT_STABLE_TIMER_BIT = 17;  // ~10.9 ms at 12 MHz
    localparam bit          BOARD_ACTIVE_LOW         = 1'b1;

    typedef enum logic [1:0] {
        CNT_CLEAR,
        CNT_COUNT,
        CNT_COMMIT
    } cnt_action_e;

    // Raw pin level of a button that is not pressed.
    function automatic logic released_level(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounced button: 2-flop synchronizer, stability counter, accepted
// level and one-cycle press/release pulses.
module button_debouncer_channel
    import button_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_TIMER_BIT = DEFAULT_STABLE_TIMER_BIT,
    parameter bit          ACTIVE_LOW       = BOARD_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic state_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned     CW       = STABLE_TIMER_BIT + 1;
    localparam logic            RELEASED = released_level(ACTIVE_LOW);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic          sync1_q, sync2_q;
    logic          sample;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    cnt_action_e   action;

    // Normalized sample: 1 means pressed, whatever the board polarity.
    assign sample = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        if (sample == state_q)
            action = CNT_CLEAR;
        else if (cnt_q[STABLE_TIMER_BIT])
            action = CNT_COMMIT;
        else
            action = CNT_COUNT;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        cnt_d     = cnt_q;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (action)
            CNT_CLEAR:  cnt_d = '0;
            CNT_COUNT:  cnt_d = cnt_q + CNT_ONE;
            CNT_COMMIT: begin
                cnt_d     = '0;
                state_d   = sample;
                press_d   = sample;
                release_d = ~sample;
            end
            default:    cnt_d = '0;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values and the two synchronizer stages really are two stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Loading the released level keeps a button held through reset
            // from looking like a fresh press.
            sync1_q   <= RELEASED;
            sync2_q   <= RELEASED;
            cnt_q     <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-button debouncer: one independent channel per pin, outputs
// concatenated into per-button vectors.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS      = DEFAULT_NUM_BUTTONS,
    parameter int unsigned STABLE_TIMER_BIT = DEFAULT_STABLE_TIMER_BIT,
    parameter bit          ACTIVE_LOW       = BOARD_ACTIVE_LOW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btn_in,
    output logic [NUM_BUTTONS-1:0] btn_state,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        button_debouncer_channel #(
            .STABLE_TIMER_BIT (STABLE_TIMER_BIT),
            .ACTIVE_LOW       (ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn_i     (btn_in[i]),
            .state_o   (btn_state[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed stimulus, a behavioural
// model compared every cycle, and hand-computed latency checkpoints.
module tb_button_debouncer;

    localparam int N   = 4;
    localparam int B   = 3;
    localparam int RUN = (1 << B) + 1;  // consecutive disagreeing samples to accept
    localparam int LAT = (1 << B) + 3;  // pin change to output, in clk edges

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_state, btn_press, btn_release;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    button_debouncer #(
        .NUM_BUTTONS      (N),
        .STABLE_TIMER_BIT (B),
        .ACTIVE_LOW       (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Model: the pin reaches the comparison two edges late; a level is accepted
    // once RUN successive samples all disagree with the current level.
    logic [N-1:0] m_pin1, m_pin2, m_state, m_press, m_rel;
    int           m_run [N];
    logic [N-1:0] n_state, n_press, n_rel, m_s;
    int           n_run [N];

    always_comb begin
        m_s     = ~m_pin2;
        n_state = m_state;
        n_press = '0;
        n_rel   = '0;
        for (int i = 0; i < N; i++) begin
            n_run[i] = 0;
            if (m_s[i] != m_state[i]) begin
                if (m_run[i] + 1 == RUN) begin
                    n_state[i] = m_s[i];
                    n_press[i] = m_s[i];
                    n_rel[i]   = ~m_s[i];
                end else begin
                    n_run[i] = m_run[i] + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pin1  <= '1;
            m_pin2  <= '1;
            m_state <= '0;
            m_press <= '0;
            m_rel   <= '0;
            for (int i = 0; i < N; i++) m_run[i] <= 0;
        end else begin
            m_pin1  <= btn_in;
            m_pin2  <= m_pin1;
            m_state <= n_state;
            m_press <= n_press;
            m_rel   <= n_rel;
            for (int i = 0; i < N; i++) m_run[i] <= n_run[i];
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model_state",   btn_state,   m_state);
            check("model_press",   btn_press,   m_press);
            check("model_release", btn_release, m_rel);
        end
    end

    // Advance n rising edges, then stop on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = '1;
        @(posedge clk);
        model_on = 1'b1;
        step(2);
        check("reset_state", btn_state, 4'b0000);
        check("reset_press", btn_press, 4'b0000);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            check("idle_state", btn_state, 4'b0000);
            check("idle_press", btn_press, 4'b0000);
        end

        // Clean press on button 0
        btn_in[0] = 1'b0;
        step(LAT - 1);
        check("press_early_state", btn_state, 4'b0000);
        step(1);
        check("press_state", btn_state, 4'b0001);
        check("press_pulse", btn_press, 4'b0001);
        check("press_no_release", btn_release, 4'b0000);
        step(1);
        check("press_pulse_end", btn_press, 4'b0000);
        step(3);

        // Clean release on button 0
        btn_in[0] = 1'b1;
        step(LAT - 1);
        check("release_early_state", btn_state, 4'b0001);
        step(1);
        check("release_state", btn_state, 4'b0000);
        check("release_pulse", btn_release, 4'b0001);
        step(1);
        check("release_pulse_end", btn_release, 4'b0000);
        step(3);

        // Glitch on button 1: 8 low samples, 1 high, then held low
        btn_in[1] = 1'b0;
        step(8);
        btn_in[1] = 1'b1;
        step(1);
        btn_in[1] = 1'b0;
        step(2);
        check("glitch_no_commit", btn_press, 4'b0000);
        check("glitch_state", btn_state, 4'b0000);
        step(LAT - 3);
        check("glitch_late_state", btn_state, 4'b0000);
        step(1);
        check("glitch_press", btn_press, 4'b0010);
        check("glitch_state_set", btn_state, 4'b0010);

        // Simultaneous press of buttons 1 and 3
        btn_in = '1;
        step(15);
        check("simul_idle", btn_state, 4'b0000);
        btn_in = 4'b0101;
        step(LAT - 1);
        check("simul_early", btn_state, 4'b0000);
        step(1);
        check("simul_state", btn_state, 4'b1010);
        check("simul_press", btn_press, 4'b1010);
        step(1);
        check("simul_press_end", btn_press, 4'b0000);

        // Reset in the middle of a count on button 2
        btn_in = '1;
        step(15);
        btn_in = 4'b1011;
        step(6);
        rst = 1'b1;
        step(1);
        check("midrst_state", btn_state, 4'b0000);
        check("midrst_press", btn_press, 4'b0000);
        rst = 1'b0;
        step(4);
        check("midrst_no_press", btn_press, 4'b0000);
        step(LAT - 5);
        check("midrst_late_state", btn_state, 4'b0000);
        step(1);
        check("midrst_press_after", btn_press, 4'b0100);
        check("midrst_state_after", btn_state, 4'b0100);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
